// File: rtl/carry_unit_4bits_pkg.sv
// Shared types for the 4-bit carry-lookahead unit.
package cla_pkg;

    localparam int unsigned CLA_WIDTH = 4;

    typedef logic [CLA_WIDTH-1:0] cla_vec_t;

endpackage : cla_pkg

// File: rtl/carry_unit_4bits_if.sv
// Operand/result bundle for carry_unit_4bits; gp/gg exist only with CARRY_UNIT_GROUP_PG_EN.
interface carry_unit_4bits_if;
    import cla_pkg::*;

    logic     in_valid;
    cla_vec_t p;
    cla_vec_t g;
    logic     c0;
    cla_vec_t c;
    logic     out_valid;
`ifdef CARRY_UNIT_GROUP_PG_EN
    logic     gp;
    logic     gg;

    modport master (output in_valid, p, g, c0, input  c, out_valid, gp, gg);
    modport slave  (input  in_valid, p, g, c0, output c, out_valid, gp, gg);
`else
    modport master (output in_valid, p, g, c0, input  c, out_valid);
    modport slave  (input  in_valid, p, g, c0, output c, out_valid);
`endif

endinterface : carry_unit_4bits_if

// File: rtl/cla_carry_comb4.sv
// Two-level sum-of-products lookahead carries; group P/G added under CARRY_UNIT_GROUP_PG_EN.
module cla_carry_comb4
    import cla_pkg::*;
(
    input  cla_vec_t p_i,
    input  cla_vec_t g_i,
    input  logic     c0_i,
`ifdef CARRY_UNIT_GROUP_PG_EN
    output logic     gp_o,
    output logic     gg_o,
`endif
    output cla_vec_t c_o
);

    // Every carry is flattened so no term depends on a lower carry.
    assign c_o[0] = g_i[0]
                  | (p_i[0] & c0_i);
    assign c_o[1] = g_i[1]
                  | (p_i[1] & g_i[0])
                  | (p_i[1] & p_i[0] & c0_i);
    assign c_o[2] = g_i[2]
                  | (p_i[2] & g_i[1])
                  | (p_i[2] & p_i[1] & g_i[0])
                  | (p_i[2] & p_i[1] & p_i[0] & c0_i);
    assign c_o[3] = g_i[3]
                  | (p_i[3] & g_i[2])
                  | (p_i[3] & p_i[2] & g_i[1])
                  | (p_i[3] & p_i[2] & p_i[1] & g_i[0])
                  | (p_i[3] & p_i[2] & p_i[1] & p_i[0] & c0_i);

`ifdef CARRY_UNIT_GROUP_PG_EN
    assign gp_o = p_i[3] & p_i[2] & p_i[1] & p_i[0];
    assign gg_o = g_i[3]
                | (p_i[3] & g_i[2])
                | (p_i[3] & p_i[2] & g_i[1])
                | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);
`endif

endmodule : cla_carry_comb4

// File: rtl/carry_unit_4bits.sv
// 4-bit carry-lookahead unit with optional output register stage (REGISTER_OUT).
// Group propagate/generate outputs are enabled by defining CARRY_UNIT_GROUP_PG_EN.
module carry_unit_4bits
    import cla_pkg::*;
#(
    parameter int unsigned REGISTER_OUT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    carry_unit_4bits_if.slave  bus
);

    cla_vec_t c_d;
`ifdef CARRY_UNIT_GROUP_PG_EN
    logic     gp_d;
    logic     gg_d;
`endif

    cla_carry_comb4 u_comb (
        .p_i  (bus.p),
        .g_i  (bus.g),
        .c0_i (bus.c0),
`ifdef CARRY_UNIT_GROUP_PG_EN
        .gp_o (gp_d),
        .gg_o (gg_d),
`endif
        .c_o  (c_d)
    );

    generate
        if (REGISTER_OUT != 0) begin : g_reg
            cla_vec_t c_q;
            logic     out_valid_q;
`ifdef CARRY_UNIT_GROUP_PG_EN
            logic     gp_q;
            logic     gg_q;
`endif

            // Results are captured every cycle; out_valid qualifies them.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    c_q         <= '0;
                    out_valid_q <= 1'b0;
`ifdef CARRY_UNIT_GROUP_PG_EN
                    gp_q        <= 1'b0;
                    gg_q        <= 1'b0;
`endif
                end else begin
                    c_q         <= c_d;
                    out_valid_q <= bus.in_valid;
`ifdef CARRY_UNIT_GROUP_PG_EN
                    gp_q        <= gp_d;
                    gg_q        <= gg_d;
`endif
                end
            end

            assign bus.c         = c_q;
            assign bus.out_valid = out_valid_q;
`ifdef CARRY_UNIT_GROUP_PG_EN
            assign bus.gp        = gp_q;
            assign bus.gg        = gg_q;
`endif
        end else begin : g_comb
            // clk/rst_n have no role in the combinational variant.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;

            assign bus.c         = c_d;
            assign bus.out_valid = bus.in_valid;
`ifdef CARRY_UNIT_GROUP_PG_EN
            assign bus.gp        = gp_d;
            assign bus.gg        = gg_d;
`endif
        end
    endgenerate

endmodule : carry_unit_4bits

// File: tb/tb_carry_unit_4bits.sv
// Directed + exhaustive bench for carry_unit_4bits, registered and combinational builds side by side.
module tb_carry_unit_4bits;
    import cla_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    carry_unit_4bits_if bus_r ();
    carry_unit_4bits_if bus_c ();

    carry_unit_4bits #(.REGISTER_OUT(1)) dut_r (.clk(clk), .rst_n(rst_n), .bus(bus_r));
    carry_unit_4bits #(.REGISTER_OUT(0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Ripple reference: c[i] = g[i] | p[i] & c[i-1].
    function automatic cla_vec_t ripple(input cla_vec_t p, input cla_vec_t g, input logic c0);
        cla_vec_t r;
        logic     cy;
        cy = c0;
        for (int i = 0; i < 4; i++) begin
            r[i] = g[i] | (p[i] & cy);
            cy   = r[i];
        end
        return r;
    endfunction

    task automatic drive(input cla_vec_t p, input cla_vec_t g, input logic c0, input logic v);
        bus_r.p = p; bus_r.g = g; bus_r.c0 = c0; bus_r.in_valid = v;
        bus_c.p = p; bus_c.g = g; bus_c.c0 = c0; bus_c.in_valid = v;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "/reg_c"},     8'(bus_r.c),         8'h00);
        check({tag, "/reg_valid"}, 8'(bus_r.out_valid), 8'h00);
`ifdef CARRY_UNIT_GROUP_PG_EN
        check({tag, "/reg_gp"},    8'(bus_r.gp),        8'h00);
        check({tag, "/reg_gg"},    8'(bus_r.gg),        8'h00);
`endif
    endtask

    // Apply one vector: combinational result at once, registered result one edge later.
    task automatic vec(input string tag, input cla_vec_t p, input cla_vec_t g,
                       input logic c0, input logic v, input cla_vec_t exp_c);
        cla_vec_t gg_vec;
        logic     exp_gp;
        logic     exp_gg;
        gg_vec = ripple(p, g, 1'b0);
        exp_gp = &p;
        exp_gg = gg_vec[3];
        drive(p, g, c0, v);
        #1;
        check({tag, "/comb_c"},     8'(bus_c.c),         8'(exp_c));
        check({tag, "/comb_valid"}, 8'(bus_c.out_valid), 8'(v));
`ifdef CARRY_UNIT_GROUP_PG_EN
        check({tag, "/comb_gp"},    8'(bus_c.gp),        8'(exp_gp));
        check({tag, "/comb_gg"},    8'(bus_c.gg),        8'(exp_gg));
`endif
        @(posedge clk);
        #1;
        check({tag, "/reg_c"},      8'(bus_r.c),         8'(exp_c));
        check({tag, "/reg_valid"},  8'(bus_r.out_valid), 8'(v));
`ifdef CARRY_UNIT_GROUP_PG_EN
        check({tag, "/reg_gp"},     8'(bus_r.gp),        8'(exp_gp));
        check({tag, "/reg_gg"},     8'(bus_r.gg),        8'(exp_gg));
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] iv;
        rst_n = 1'b0;
        drive(4'hF, 4'hF, 1'b1, 1'b1);
        #2;
        check_reset("rst_async");
        check("rst_comb_c",     8'(bus_c.c),         8'h0F);
        check("rst_comb_valid", 8'(bus_c.out_valid), 8'h01);
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst_held");
        @(negedge clk);
        rst_n = 1'b1;

        vec("fullprop_c1", 4'b1111, 4'b0000, 1'b1, 1'b1, 4'b1111);
        vec("fullprop_c0", 4'b1111, 4'b0000, 1'b0, 1'b1, 4'b0000);
        vec("isogen",      4'b0000, 4'b0101, 1'b0, 1'b1, 4'b0101);
        vec("chain",       4'b1010, 4'b0101, 1'b0, 1'b1, 4'b1111);
        vec("chain_p0",    4'b0000, 4'b0101, 1'b0, 1'b1, 4'b0101);
        vec("novalid",     4'b1010, 4'b0101, 1'b0, 1'b0, 4'b1111);
        vec("revalid",     4'b0000, 4'b0101, 1'b0, 1'b1, 4'b0101);
        vec("pg_both",     4'b1111, 4'b1111, 1'b0, 1'b1, 4'b1111);
        vec("mid_gen",     4'b1100, 4'b0010, 1'b0, 1'b1, 4'b1110);
        vec("blocked",     4'b1011, 4'b0000, 1'b1, 1'b1, 4'b0011);

        // Async reset mid-stream: registered outputs clear without an edge.
        #3;
        rst_n = 1'b0;
        #1;
        check_reset("rst_mid");
        check("rst_mid_comb_c", 8'(bus_c.c), 8'h03);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 512; i++) begin
            iv = 9'(i);
            if (i == 256) begin
                rst_n = 1'b0;
                #1;
                check_reset("rst_sweep");
                @(negedge clk);
                rst_n = 1'b1;
            end
            vec("sweep", iv[3:0], iv[7:4], iv[8], ^iv[2:0], ripple(iv[3:0], iv[7:4], iv[8]));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_carry_unit_4bits

// File: doc/carry_unit_4bits.md
Name: carry_unit_4bits

Overview:
- 4-bit carry-lookahead unit. Takes per-bit propagate/generate terms and a carry-in, and produces the four lookahead carries in parallel (no ripple).
- Sits beside the 4-bit adder slices of the MIPS ALU. Can be cascaded via group P/G (optional) for wider lookahead.
- Output is registered by default for timing closure in the ALU pipeline.

Parameters:
- REGISTER_OUT, 1, 1 = outputs registered (1-cycle latency); 0 = outputs purely combinational (clk/rst_n unused for data path).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  qualifies p/g/c0 this cycle
- p  input  4  per-bit propagate, p[i] = a[i] ^ b[i]
- g  input  4  per-bit generate, g[i] = a[i] & b[i]
- c0  input  1  carry into bit 0
- c  output  4  lookahead carries; c[i] = carry out of bit i (c[3] = carry-out of nibble)
- out_valid  output  1  qualifies c (and gp/gg when enabled)

Behaviour:
- Equations, all computed in parallel as two-level sum-of-products, no chained terms:
  - c[0] = g0 | p0·c0
  - c[1] = g1 | p1·g0 | p1·p0·c0
  - c[2] = g2 | p2·g1 | p2·p1·g0 | p2·p1·p0·c0
  - c[3] = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0 | p3·p2·p1·p0·c0
- p and g are not required to be mutually exclusive. Equations hold as written for any input combination, including p[i]=g[i]=1.
- REGISTER_OUT=1:
  - On each rising clk edge, c <= equations(p,g,c0) and out_valid <= in_valid.
  - Latency is exactly 1 cycle. Throughput is 1 result per cycle, with no stall/backpressure.
  - c is captured every cycle regardless of in_valid. Consumers must qualify c with out_valid.
- REGISTER_OUT=0: c = equations combinationally; out_valid = in_valid.
- Reset:
  - rst_n low immediately forces c=4'b0000 and out_valid=0 (and gp/gg=0 when enabled), asynchronously and independent of clk.
  - Reset deasserting mid-stream: the first valid output is the one captured at the first rising edge with rst_n high.
  - Reset has no effect on the combinational variant.
- No internal state beyond the output registers. No X-propagation tolerance required; inputs are driven.

Optional Feature:
- Macro CARRY_UNIT_GROUP_PG_EN.
- Defined:
  - Adds outputs gp (1 bit) = p3·p2·p1·p0 and gg (1 bit) = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0.
  - Both use the same latency/register/reset rules as c, for use by a second-level 16-bit lookahead unit.
- Undefined: ports gp/gg do not exist; behaviour otherwise identical.

Decomposition:
- Shared package cla_pkg:
  - constant CLA_WIDTH = 4
  - typedef cla_vec_t = logic [CLA_WIDTH-1:0], used for p, g, c
- One natural sub-module: cla_carry_comb4.
  - Pure combinational equations, producing c, plus gp/gg when the macro is defined.
  - Instantiated by carry_unit_4bits, which adds the optional register stage and valid pipeline.

Test Plan:
- Reset: rst_n=0 with p=4'hF, g=4'hF, c0=1 and clock running -> c=4'b0000 and out_valid=0 immediately, without waiting for a clock edge.
- Full propagate: p=4'b1111, g=4'b0000, c0=1, in_valid=1 -> one cycle later c=4'b1111, out_valid=1. With c0=0 -> c=4'b0000 (gp=1, gg=0 when enabled).
- Isolated generates: p=4'b0000, g=4'b0101, c0=0 -> c=4'b0101 after 1 cycle.
- Chained lookahead: p=4'b1010, g=4'b0101, c0=0 -> c=4'b1111 (gg=1 when enabled). Same inputs with p=4'b0000 -> c=4'b0101.
- Back-to-back: present the three vectors above on consecutive cycles with in_valid=1 -> results emerge on consecutive cycles in order, each 1 cycle after its input. Drop in_valid for one cycle -> out_valid low exactly one cycle later.
- Exhaustive: all 512 combinations of p/g/c0 compared against a ripple reference model (c[i] = g[i] | p[i]·c[i-1]). Run for REGISTER_OUT=1 and REGISTER_OUT=0, and with and without CARRY_UNIT_GROUP_PG_EN. Reset asserted mid-sweep -> outputs clear and sweep resumes cleanly.
